// File: rtl/axil_mst_pkg.sv
// Shared definitions for the AXI4-Lite command master: FSM encoding,
// AXI response codes and the pattern returned when a transaction is abandoned.
package axil_mst_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    WRESP,
    RADDR,
    RDATA,
    RSP
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

  // States in which the master is waiting on the slave.
  function automatic logic is_busy(state_t s);
    return (s == WRITE) || (s == WRESP) || (s == RADDR) || (s == RDATA);
  endfunction

endpackage

// File: rtl/axil_lite_master_if.sv
// AXI4-Lite bus bundle between the command master and a register-bank slave.
interface axil_lite_master_if #(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 12
);

  logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR;
  logic                            M_AXI_AWVALID;
  logic                            M_AXI_AWREADY;
  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA;
  logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB;
  logic                            M_AXI_WVALID;
  logic                            M_AXI_WREADY;
  logic [1:0]                      M_AXI_BRESP;
  logic                            M_AXI_BVALID;
  logic                            M_AXI_BREADY;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR;
  logic                            M_AXI_ARVALID;
  logic                            M_AXI_ARREADY;
  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA;
  logic [1:0]                      M_AXI_RRESP;
  logic                            M_AXI_RVALID;
  logic                            M_AXI_RREADY;

  modport master (
    output M_AXI_AWADDR, M_AXI_AWVALID, input M_AXI_AWREADY,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, input M_AXI_WREADY,
    input M_AXI_BRESP, M_AXI_BVALID, output M_AXI_BREADY,
    output M_AXI_ARADDR, M_AXI_ARVALID, input M_AXI_ARREADY,
    input M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID, output M_AXI_RREADY
  );

  modport slave (
    input M_AXI_AWADDR, M_AXI_AWVALID, output M_AXI_AWREADY,
    input M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, output M_AXI_WREADY,
    output M_AXI_BRESP, M_AXI_BVALID, input M_AXI_BREADY,
    input M_AXI_ARADDR, M_AXI_ARVALID, output M_AXI_ARREADY,
    output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID, input M_AXI_RREADY
  );

endinterface

// File: rtl/axil_mst_watchdog.sv
// Cycle counter that flags a stalled transaction; restarts on every state
// change and only counts while the master is waiting on the slave.
module axil_mst_watchdog #(
  parameter int C_TIMEOUT_CYCLES = 256
) (
  input  logic S_AXI_ACLK,
  input  logic S_AXI_ARESETN,
  input  logic restart,
  input  logic active,
  output logic expired
);

  localparam int CNT_W = $clog2(C_TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      count <= '0;
    end else if (restart) begin
      count <= '0;
    end else if (active && !expired) begin
      count <= count + 1'b1;
    end
  end

  // Fires during the last permitted cycle so the master leaves on that edge.
  assign expired = active && (count == CNT_W'(C_TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/axil_lite_master.sv
// Single-outstanding AXI4-Lite initiator: one command in, one AXI transaction,
// one response out. Define AXIL_MST_TIMEOUT_EN to add the stall watchdog.
module axil_lite_master
  import axil_mst_pkg::*;
#(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 12,
  parameter int C_TIMEOUT_CYCLES   = 256
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,
  axil_lite_master_if.master              m_axi
);

  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int SW = C_M_AXI_DATA_WIDTH / 8;
  localparam logic [AW-1:0] ALIGN_MASK = {{(AW-2){1'b1}}, 2'b00};

  state_t          state, state_n;
  logic            aw_done, aw_done_n, w_done, w_done_n;
  logic [AW-1:0]   addr_q, addr_n;
  logic [DW-1:0]   wdata_q, wdata_n;
  logic [SW-1:0]   wstrb_q, wstrb_n;
  logic            awvalid_q, awvalid_n, wvalid_q, wvalid_n, bready_q, bready_n;
  logic            arvalid_q, arvalid_n, rready_q, rready_n;
  logic            cmd_ready_n, rsp_valid_n;
  logic [DW-1:0]   rsp_rdata_n;
  logic [1:0]      rsp_resp_n;
  logic            timeout;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state     <= IDLE;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= RESP_OKAY;
    end else begin
      state     <= state_n;
      aw_done   <= aw_done_n;
      w_done    <= w_done_n;
      addr_q    <= addr_n;
      wdata_q   <= wdata_n;
      wstrb_q   <= wstrb_n;
      awvalid_q <= awvalid_n;
      wvalid_q  <= wvalid_n;
      bready_q  <= bready_n;
      arvalid_q <= arvalid_n;
      rready_q  <= rready_n;
      cmd_ready <= cmd_ready_n;
      rsp_valid <= rsp_valid_n;
      rsp_rdata <= rsp_rdata_n;
      rsp_resp  <= rsp_resp_n;
    end
  end

  // Every output is a flop, so next values for them are computed here with the state.
  always_comb begin
    state_n     = state;
    aw_done_n   = aw_done;
    w_done_n    = w_done;
    addr_n      = addr_q;
    wdata_n     = wdata_q;
    wstrb_n     = wstrb_q;
    awvalid_n   = awvalid_q;
    wvalid_n    = wvalid_q;
    bready_n    = bready_q;
    arvalid_n   = arvalid_q;
    rready_n    = rready_q;
    rsp_valid_n = rsp_valid;
    rsp_rdata_n = rsp_rdata;
    rsp_resp_n  = rsp_resp;

    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          addr_n  = cmd_addr & ALIGN_MASK;
          wdata_n = cmd_wdata;
          wstrb_n = cmd_wstrb;
          if (cmd_write) begin
            awvalid_n = 1'b1;
            wvalid_n  = 1'b1;
            aw_done_n = 1'b0;
            w_done_n  = 1'b0;
            state_n   = WRITE;
          end else begin
            arvalid_n = 1'b1;
            state_n   = RADDR;
          end
        end
      end
      WRITE: begin
        if (awvalid_q && m_axi.M_AXI_AWREADY) begin
          awvalid_n = 1'b0;
          aw_done_n = 1'b1;
        end
        if (wvalid_q && m_axi.M_AXI_WREADY) begin
          wvalid_n = 1'b0;
          w_done_n = 1'b1;
        end
        if (aw_done_n && w_done_n) begin
          bready_n = 1'b1;
          state_n  = WRESP;
        end
      end
      WRESP: begin
        if (m_axi.M_AXI_BVALID) begin
          bready_n    = 1'b0;
          rsp_resp_n  = m_axi.M_AXI_BRESP;
          rsp_rdata_n = '0;
          rsp_valid_n = 1'b1;
          state_n     = RSP;
        end
      end
      RADDR: begin
        if (m_axi.M_AXI_ARREADY) begin
          arvalid_n = 1'b0;
          rready_n  = 1'b1;
          state_n   = RDATA;
        end
      end
      RDATA: begin
        if (m_axi.M_AXI_RVALID) begin
          rready_n    = 1'b0;
          rsp_resp_n  = m_axi.M_AXI_RRESP;
          rsp_rdata_n = m_axi.M_AXI_RDATA;
          rsp_valid_n = 1'b1;
          state_n     = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_n = 1'b0;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    // Stall recovery deliberately abandons the bus handshake mid-flight.
    if (timeout) begin
      awvalid_n   = 1'b0;
      wvalid_n    = 1'b0;
      bready_n    = 1'b0;
      arvalid_n   = 1'b0;
      rready_n    = 1'b0;
      rsp_resp_n  = RESP_DECERR;
      rsp_rdata_n = DW'(TIMEOUT_RDATA);
      rsp_valid_n = 1'b1;
      state_n     = RSP;
    end

    cmd_ready_n = (state_n == IDLE);
  end

`ifdef AXIL_MST_TIMEOUT_EN
  axil_mst_watchdog #(
    .C_TIMEOUT_CYCLES(C_TIMEOUT_CYCLES)
  ) u_watchdog (
    .S_AXI_ACLK   (S_AXI_ACLK),
    .S_AXI_ARESETN(S_AXI_ARESETN),
    .restart      (state_n != state),
    .active       (is_busy(state)),
    .expired      (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  assign m_axi.M_AXI_AWADDR  = addr_q;
  assign m_axi.M_AXI_AWVALID = awvalid_q;
  assign m_axi.M_AXI_WDATA   = wdata_q;
  assign m_axi.M_AXI_WSTRB   = wstrb_q;
  assign m_axi.M_AXI_WVALID  = wvalid_q;
  assign m_axi.M_AXI_BREADY  = bready_q;
  assign m_axi.M_AXI_ARADDR  = addr_q;
  assign m_axi.M_AXI_ARVALID = arvalid_q;
  assign m_axi.M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axil_lite_master.sv
// Scoreboard bench for axil_lite_master against a behavioural register-bank
// slave with programmable AW/W stalls, blocked AR/R and an SLVERR address.
module tb_axil_lite_master;

  localparam int AW = 12;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [3:0]    cmd_wstrb;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;

  always #5 clk = ~clk;

  axil_lite_master_if #(.C_M_AXI_DATA_WIDTH(DW), .C_M_AXI_ADDR_WIDTH(AW)) bus ();

  axil_lite_master #(
    .C_M_AXI_DATA_WIDTH(DW),
    .C_M_AXI_ADDR_WIDTH(AW),
    .C_TIMEOUT_CYCLES  (256)
  ) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESETN(rstn),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_write    (cmd_write),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .cmd_wstrb    (cmd_wstrb),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_resp     (rsp_resp),
    .m_axi        (bus)
  );

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          lat;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Slave model state
  logic [31:0] mem [64];
  int          aw_delay = 0, w_delay = 0, aw_cnt = 0, w_cnt = 0, b_count = 0;
  bit          ar_block = 0, r_block = 0;
  bit          have_aw = 0, have_w = 0, b_pending = 0, r_pending = 0;
  logic [AW-1:0] last_awaddr = '0, last_araddr = '0;
  logic [31:0] w_data_l = '0, r_data_l = '0;
  logic [3:0]  w_strb_l = '0;
  logic [1:0]  r_resp_l = '0;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[63] = 32'h0BAD_F00D;
    bus.M_AXI_AWREADY = 1'b0;
    bus.M_AXI_WREADY  = 1'b0;
    bus.M_AXI_BVALID  = 1'b0;
    bus.M_AXI_BRESP   = 2'b00;
    bus.M_AXI_ARREADY = 1'b0;
    bus.M_AXI_RVALID  = 1'b0;
    bus.M_AXI_RDATA   = '0;
    bus.M_AXI_RRESP   = 2'b00;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        have_aw = 0; have_w = 0; b_pending = 0; r_pending = 0; aw_cnt = 0; w_cnt = 0;
      end else begin
        if (bus.M_AXI_AWVALID && bus.M_AXI_AWREADY) begin
          have_aw = 1; last_awaddr = bus.M_AXI_AWADDR; aw_cnt = 0;
        end else if (bus.M_AXI_AWVALID) aw_cnt++;
        if (bus.M_AXI_WVALID && bus.M_AXI_WREADY) begin
          have_w = 1; w_data_l = bus.M_AXI_WDATA; w_strb_l = bus.M_AXI_WSTRB; w_cnt = 0;
        end else if (bus.M_AXI_WVALID) w_cnt++;
        if (bus.M_AXI_BVALID && bus.M_AXI_BREADY) begin
          b_pending = 0; b_count++;
        end
        if (bus.M_AXI_RVALID && bus.M_AXI_RREADY) r_pending = 0;
        if (bus.M_AXI_ARVALID && bus.M_AXI_ARREADY) begin
          r_pending   = 1;
          last_araddr = bus.M_AXI_ARADDR;
          r_data_l    = mem[bus.M_AXI_ARADDR[7:2]];
          r_resp_l    = (bus.M_AXI_ARADDR == 12'h0FC) ? 2'b10 : 2'b00;
        end
        if (have_aw && have_w) begin
          for (int b = 0; b < 4; b++)
            if (w_strb_l[b]) mem[last_awaddr[7:2]][b*8 +: 8] = w_data_l[b*8 +: 8];
          b_pending = 1; have_aw = 0; have_w = 0;
        end
      end
      @(posedge clk);
      #1;
      bus.M_AXI_AWREADY = bus.M_AXI_AWVALID && (aw_cnt >= aw_delay);
      bus.M_AXI_WREADY  = bus.M_AXI_WVALID && (w_cnt >= w_delay);
      bus.M_AXI_ARREADY = bus.M_AXI_ARVALID && !ar_block;
      bus.M_AXI_BVALID  = b_pending;
      bus.M_AXI_RVALID  = r_pending && !r_block;
      bus.M_AXI_RDATA   = r_data_l;
      bus.M_AXI_RRESP   = r_resp_l;
    end
  end

  // Response monitor: pops the scoreboard on every rsp handshake.
  bit   prev_valid = 0;
  int   first_cyc = 0;
  exp_t ent;

  always @(negedge clk) begin
    if (!rstn) begin
      prev_valid = 0;
    end else begin
      if (rsp_valid && !prev_valid) first_cyc = cyc;
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          ent = exp_q.pop_front();
          check("rsp_rdata", rsp_rdata, ent.rdata);
          check("rsp_resp", 32'(rsp_resp), 32'(ent.resp));
          if (ent.lat >= 0) check("rsp_latency", 32'(first_cyc - ent.acc + 1), 32'(ent.lat));
        end
      end
      prev_valid = rsp_valid;
    end
  end

  task automatic send_cmd(input logic wr, input logic [AW-1:0] addr, input logic [31:0] wd,
                          input logic [3:0] ws, input logic [31:0] exp_rd,
                          input logic [1:0] exp_rs, input int exp_lat);
    exp_t e;
    bit   accepted = 0;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = ws;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        e.rdata = exp_rd; e.resp = exp_rs; e.lat = exp_lat; e.acc = cyc + 1;
        exp_q.push_back(e);
        accepted = 1;
        break;
      end
    end
    if (!accepted) check("cmd_accept", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) return;
    end
    check("rsp_drain", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    check({tag, "_rsp_resp"}, 32'(rsp_resp), 32'd0);
    check({tag, "_valids"}, 32'({bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_ARVALID}), 32'd0);
    check({tag, "_readys"}, 32'({bus.M_AXI_BREADY, bus.M_AXI_RREADY}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not complete");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    int b_before;
    bit seen;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1'b1;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1 rstn = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_cmd_ready", 32'(cmd_ready), 32'd1);

    // Zero-wait write/read, including strobes and low-address-bit masking.
    send_cmd(1'b1, 12'h008, 32'hA5A5_5A5A, 4'hF, 32'h0, 2'b00, 3);
    drain(20);
    check("awaddr_008", 32'(last_awaddr), 32'h008);
    send_cmd(1'b1, 12'h013, 32'h1234_5678, 4'b0011, 32'h0, 2'b00, 3);
    drain(20);
    check("awaddr_masked", 32'(last_awaddr), 32'h010);
    send_cmd(1'b0, 12'h008, 32'h0, 4'h0, 32'hA5A5_5A5A, 2'b00, 3);
    drain(20);
    check("araddr_008", 32'(last_araddr), 32'h008);
    send_cmd(1'b0, 12'h013, 32'h0, 4'h0, 32'h0000_5678, 2'b00, 3);
    drain(20);
    check("araddr_masked", 32'(last_araddr), 32'h010);

    // AWREADY four cycles behind WREADY.
    aw_delay = 4;
    b_before = b_count;
    send_cmd(1'b1, 12'h020, 32'hCAFE_F00D, 4'hF, 32'h0, 2'b00, -1);
    @(negedge clk);
    repeat (3) begin
      @(negedge clk);
      check("split_wvalid_dropped", 32'(bus.M_AXI_WVALID), 32'd0);
      check("split_awvalid_held", 32'(bus.M_AXI_AWVALID), 32'd1);
    end
    drain(30);
    check("split_b_count", 32'(b_count - b_before), 32'd1);
    aw_delay = 0;

    // WREADY behind AWREADY.
    w_delay = 2;
    send_cmd(1'b1, 12'h024, 32'h0F0F_1E1E, 4'hF, 32'h0, 2'b00, -1);
    drain(30);
    w_delay = 0;
    send_cmd(1'b0, 12'h020, 32'h0, 4'h0, 32'hCAFE_F00D, 2'b00, 3);
    drain(20);
    send_cmd(1'b0, 12'h024, 32'h0, 4'h0, 32'h0F0F_1E1E, 2'b00, 3);
    drain(20);

    // SLVERR read, then back to idle.
    send_cmd(1'b0, 12'h0FC, 32'h0, 4'h0, 32'h0BAD_F00D, 2'b10, 3);
    drain(20);
    @(negedge clk);
    check("slverr_back_idle", 32'(cmd_ready), 32'd1);

    // Response held off by the requester.
    rsp_ready = 1'b0;
    send_cmd(1'b0, 12'h008, 32'h0, 4'h0, 32'hA5A5_5A5A, 2'b00, 3);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) begin seen = 1; break; end
    end
    check("hold_rsp_seen", 32'(seen), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      check("hold_rsp_rdata", rsp_rdata, 32'hA5A5_5A5A);
      check("hold_rsp_resp", 32'(rsp_resp), 32'd0);
      check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
      check("hold_no_aw", 32'(bus.M_AXI_AWVALID), 32'd0);
      if (i == 2) begin cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h030; end
      if (i == 3) cmd_valid = 1'b0;
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    drain(10);
    repeat (6) @(negedge clk);
    check("hold_pulse_ignored", 32'(bus.M_AXI_AWVALID), 32'd0);

    // Reset while waiting for R.
    r_block = 1;
    send_cmd(1'b0, 12'h008, 32'h0, 4'h0, 32'hA5A5_5A5A, 2'b00, -1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.M_AXI_RREADY) begin seen = 1; break; end
    end
    check("rdata_reached", 32'(seen), 32'd1);
    #2 rstn = 1'b0;
    #1;
    check_all_zero("async_reset");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    r_block = 0;
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    check("post_reset_idle", 32'(cmd_ready), 32'd1);
    check("post_reset_rready", 32'(bus.M_AXI_RREADY), 32'd0);
    send_cmd(1'b0, 12'h008, 32'h0, 4'h0, 32'hA5A5_5A5A, 2'b00, 3);
    drain(20);

`ifdef AXIL_MST_TIMEOUT_EN
    // Slave never accepts AR: watchdog must give up.
    ar_block = 1;
    send_cmd(1'b0, 12'h030, 32'h0, 4'h0, 32'hDEAD_BEEF, 2'b11, -1);
    seen = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (rsp_valid) begin seen = 1; break; end
    end
    check("timeout_rsp_seen", 32'(seen), 32'd1);
    check("timeout_arvalid", 32'(bus.M_AXI_ARVALID), 32'd0);
    drain(10);
    ar_block = 0;
`endif

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
